// File: rtl/inorder_queue_ctrl.sv
// Pointer/occupancy controller for a circular in-order queue (ROB/LSQ style).
// Per-entry valid/done bits live in an array of inorder_queue_entry instances.
module inorder_queue_entry (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic alloc,
    input  logic dealloc,
    input  logic wb,
    output logic valid,
    output logic done
);
    // clear (flush or squash) beats a same-cycle writeback to this entry
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            valid <= 1'b0;
            done  <= 1'b0;
        end else if (dealloc) begin
            valid <= 1'b0;
            done  <= 1'b0;
        end else if (alloc) begin
            valid <= 1'b1;
            done  <= 1'b0;
        end else if (wb && valid) begin
            done <= 1'b1;
        end
    end
endmodule

module inorder_queue_ctrl #(
    parameter int QUEUE_SIZE     = 8,
    parameter int QUEUE_SIZE_LOG = 3
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enq_valid,
    output logic                      enq_ready,
    output logic [QUEUE_SIZE_LOG:0]   enq_ptr,
    output logic [QUEUE_SIZE-1:0]     enq_ptr_oh,
    input  logic                      wb_valid,
    input  logic [QUEUE_SIZE_LOG:0]   wb_ptr,
    output logic                      deq_valid,
    input  logic                      deq_ready,
    output logic [QUEUE_SIZE_LOG:0]   deq_ptr,
    output logic [QUEUE_SIZE-1:0]     deq_ptr_oh,
    input  logic                      redirect_valid,
    input  logic [QUEUE_SIZE_LOG:0]   redirect_ptr,
    input  logic                      flush,
    output logic [QUEUE_SIZE-1:0]     entry_valid,
    output logic [QUEUE_SIZE_LOG:0]   count,
    output logic                      full,
    output logic                      empty
);
    localparam int PW = QUEUE_SIZE_LOG + 1;

    logic [QUEUE_SIZE-1:0]     done;
    logic [QUEUE_SIZE-1:0]     wb_oh;
    logic [QUEUE_SIZE-1:0]     squash;
    logic [QUEUE_SIZE_LOG:0]   redir_dist;
    logic                      enq_fire;
    logic                      deq_fire;
    logic                      unused_wb_wrap;

    assign empty      = (enq_ptr == deq_ptr);
    assign full       = (enq_ptr[QUEUE_SIZE_LOG-1:0] == deq_ptr[QUEUE_SIZE_LOG-1:0]) &&
                        (enq_ptr[QUEUE_SIZE_LOG] != deq_ptr[QUEUE_SIZE_LOG]);
    assign count      = enq_ptr - deq_ptr;
    assign enq_ready  = ~full & ~flush & ~redirect_valid;
    assign enq_fire   = enq_valid & enq_ready;
    assign deq_valid  = ~empty & done[deq_ptr[QUEUE_SIZE_LOG-1:0]];
    assign deq_fire   = deq_valid & deq_ready & ~flush;

    assign enq_ptr_oh = QUEUE_SIZE'(1) << enq_ptr[QUEUE_SIZE_LOG-1:0];
    assign deq_ptr_oh = QUEUE_SIZE'(1) << deq_ptr[QUEUE_SIZE_LOG-1:0];
    assign wb_oh      = QUEUE_SIZE'(1) << wb_ptr[QUEUE_SIZE_LOG-1:0];
    assign unused_wb_wrap = wb_ptr[QUEUE_SIZE_LOG];

    // Age is measured as distance from the head so wrap never confuses ordering
    assign redir_dist = redirect_ptr - deq_ptr;

    for (genvar i = 0; i < QUEUE_SIZE; i++) begin : g_entry
        logic [QUEUE_SIZE_LOG:0] entry_dist;
        assign entry_dist = {1'b0, QUEUE_SIZE_LOG'(i) - deq_ptr[QUEUE_SIZE_LOG-1:0]};
        assign squash[i]  = redirect_valid & ~flush &
                            (entry_dist > redir_dist) & (entry_dist < count);

        inorder_queue_entry u_entry (
            .clock   (clock),
            .reset   (reset),
            .clear   (flush | squash[i]),
            .alloc   (enq_fire & enq_ptr_oh[i]),
            .dealloc (deq_fire & deq_ptr_oh[i]),
            .wb      (wb_valid & ~flush & wb_oh[i]),
            .valid   (entry_valid[i]),
            .done    (done[i])
        );
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            enq_ptr <= '0;
            deq_ptr <= '0;
        end else if (flush) begin
            enq_ptr <= deq_ptr;
        end else if (redirect_valid) begin
            enq_ptr <= redirect_ptr + PW'(1);
            if (deq_fire) deq_ptr <= deq_ptr + PW'(1);
        end else begin
            if (enq_fire) enq_ptr <= enq_ptr + PW'(1);
            if (deq_fire) deq_ptr <= deq_ptr + PW'(1);
        end
    end

    a_redirect_in_range: assert property (@(posedge clock) disable iff (reset)
        (redirect_valid && !flush) |-> (redir_dist < count));
endmodule
